// File: rtl/bpi_sequencer_multi.sv
// bpi_sequencer_multi
// Command sequencer for the BPI flash interface engine. After reset it runs a
// power-up flow (Set_Cnfg_Reg, gap, Read_Array) and then waits in IDLE for a
// host request. A request runs in one of three modes:
//   0 simple        : issue the command once.
//   1 status-polled : issue, then poll the status register until the
//                     program/erase controller is idle or the poll limit is hit.
//   2 lock-verified : issue, then read the electronic signature and check
//                     the lock bits.
// Failed commands are reissued up to MAX_RETRY times (each reissue is preceded
// by Clr_Status_Reg). After that, or after a poll timeout, the error is
// reported and held until the host acknowledges it.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   start             host request, held until seq_cmplt
//   mode[1:0]         sequence mode (3 is reserved and ignored)
//   seq_cmnd          user command to issue
//   seq_done          engine finished the current command
//   pec_busy, error   status-register decode, valid in STAT_CHK
//   lk_ok             lock bits match, valid in LK_CHK
//   ack               host acknowledges a reported error
//   command           registered command to the engine
//   seqr_idle, seq_cmplt, rpt_error, check_stat, cnfrm_lk  state decodes
//   timeout_err       last failure was a poll timeout (sticky)
//   retry_cnt         reissues performed in the current sequence
//   OUT_STATE         current state encoding for debug
//
// Handshake: `command` holds its value for the whole time the FSM sits in a
// wait state; the engine raises seq_done for one cycle when it is finished,
// and seq_done is sampled only in wait states (it is ignored everywhere else).
module bpi_sequencer_multi #(
  parameter int                CMD_W     = 5,
  parameter int                POLL_W    = 16,
  parameter logic [POLL_W-1:0] MAX_POLL  = 16'd1000,
  parameter int                RETRY_W   = 2,
  parameter int                MAX_RETRY = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [CMD_W-1:0]   seq_cmnd,
  input  logic               seq_done,
  input  logic               pec_busy,
  input  logic               error,
  input  logic               lk_ok,
  input  logic               ack,
  output logic [CMD_W-1:0]   command,
  output logic               seqr_idle,
  output logic               seq_cmplt,
  output logic               rpt_error,
  output logic               check_stat,
  output logic               cnfrm_lk,
  output logic               timeout_err,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [4:0]         OUT_STATE
);

  localparam logic [4:0] RESET      = 5'd0;
  localparam logic [4:0] SET_ASYNCH = 5'd1;
  localparam logic [4:0] GAP_A      = 5'd2;
  localparam logic [4:0] RD_ARRAY   = 5'd3;
  localparam logic [4:0] IDLE       = 5'd4;
  localparam logic [4:0] SIMPLE     = 5'd5;
  localparam logic [4:0] ISSUE      = 5'd6;
  localparam logic [4:0] GAP_S      = 5'd7;
  localparam logic [4:0] STAT_RD    = 5'd8;
  localparam logic [4:0] STAT_CHK   = 5'd9;
  localparam logic [4:0] RES_MODE   = 5'd10;
  localparam logic [4:0] GAP_E      = 5'd11;
  localparam logic [4:0] ES_RD      = 5'd12;
  localparam logic [4:0] LK_CHK     = 5'd13;
  localparam logic [4:0] FAIL       = 5'd14;
  localparam logic [4:0] ERR        = 5'd15;
  localparam logic [4:0] CLR_SR     = 5'd16;
  localparam logic [4:0] DONE       = 5'd17;

  localparam logic [CMD_W-1:0] CMD_NOOP     = '0;
  localparam logic [CMD_W-1:0] CMD_READ_1   = CMD_W'(5'h02);
  localparam logic [CMD_W-1:0] CMD_RD_ARRAY = CMD_W'(5'h05);
  localparam logic [CMD_W-1:0] CMD_RD_ESIG  = CMD_W'(5'h07);
  localparam logic [CMD_W-1:0] CMD_CLR_SR   = CMD_W'(5'h09);
  localparam logic [CMD_W-1:0] CMD_SET_CNFG = CMD_W'(5'h12);

  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  logic [4:0]         state_q,      state_d;
  logic [CMD_W-1:0]   cmd_q,        cmd_d;
  logic [CMD_W-1:0]   lat_cmd_q,    lat_cmd_d;
  logic [1:0]         mode_q,       mode_d;
  logic               op_active_q,  op_active_d;
  logic [RETRY_W-1:0] retry_cnt_q,  retry_cnt_d;
  logic               retry_flag_q, retry_flag_d;
  logic [POLL_W-1:0]  poll_cnt_q,   poll_cnt_d;
  logic               timeout_q,    timeout_d;

  logic accept;

  assign accept = (state_q == IDLE) && start && (mode != 2'd3);

  always_comb begin
    state_d      = state_q;
    lat_cmd_d    = lat_cmd_q;
    mode_d       = mode_q;
    op_active_d  = op_active_q;
    retry_cnt_d  = retry_cnt_q;
    retry_flag_d = retry_flag_q;
    poll_cnt_d   = poll_cnt_q;
    timeout_d    = timeout_q;

    case (state_q)
      RESET:      state_d = SET_ASYNCH;
      SET_ASYNCH: if (seq_done) state_d = GAP_A;
      GAP_A:      state_d = RD_ARRAY;
      // The same read-array tail serves power-up and the end of a sequence;
      // op_active tells the two apart.
      RD_ARRAY:   if (seq_done) state_d = op_active_q ? DONE : IDLE;
      IDLE: begin
        if (accept) begin
          lat_cmd_d    = seq_cmnd;
          mode_d       = mode;
          op_active_d  = 1'b1;
          retry_cnt_d  = '0;
          retry_flag_d = 1'b0;
          poll_cnt_d   = '0;
          timeout_d    = 1'b0;
          state_d      = (mode == 2'd0) ? SIMPLE : ISSUE;
        end
      end
      SIMPLE:     if (seq_done) state_d = DONE;
      ISSUE:      if (seq_done) state_d = GAP_S;
      GAP_S:      state_d = (mode_q == 2'd1) ? STAT_RD : RES_MODE;
      STAT_RD:    if (seq_done) state_d = STAT_CHK;
      STAT_CHK: begin
        if (pec_busy) begin
          if (poll_cnt_q < MAX_POLL) begin
            poll_cnt_d = poll_cnt_q + POLL_W'(1);
            state_d    = STAT_RD;
          end else begin
            timeout_d = 1'b1;
            state_d   = ERR;
          end
        end else begin
          state_d = error ? FAIL : GAP_A;
        end
      end
      RES_MODE:   if (seq_done) state_d = GAP_E;
      GAP_E:      state_d = ES_RD;
      ES_RD:      if (seq_done) state_d = LK_CHK;
      LK_CHK:     state_d = lk_ok ? GAP_A : FAIL;
      FAIL: begin
        if (retry_cnt_q < RETRY_LIM) begin
          retry_cnt_d  = retry_cnt_q + RETRY_W'(1);
          retry_flag_d = 1'b1;
          state_d      = CLR_SR;
        end else begin
          state_d = ERR;
        end
      end
      ERR: begin
        if (ack) begin
          retry_flag_d = 1'b0;
          state_d      = CLR_SR;
        end
      end
      // After a host-acknowledged error the status is cleared and the flow
      // finishes through read-array instead of reissuing.
      CLR_SR:     if (seq_done) state_d = retry_flag_q ? ISSUE : GAP_A;
      DONE: begin
        if (!start) begin
          op_active_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default:    state_d = RESET;
    endcase

    // Each (re)issue gets a fresh poll budget.
    if ((state_d == ISSUE) && (state_q != ISSUE)) poll_cnt_d = '0;
  end

  // The command register is loaded from the next state so that it changes
  // together with the state register.
  always_comb begin
    cmd_d = CMD_NOOP;
    case (state_d)
      SET_ASYNCH:      cmd_d = CMD_SET_CNFG;
      RD_ARRAY:        cmd_d = CMD_RD_ARRAY;
      SIMPLE, ISSUE:   cmd_d = lat_cmd_d;
      STAT_RD, ES_RD:  cmd_d = CMD_READ_1;
      RES_MODE:        cmd_d = CMD_RD_ESIG;
      CLR_SR:          cmd_d = CMD_CLR_SR;
      default:         cmd_d = CMD_NOOP;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= RESET;
      cmd_q        <= '0;
      lat_cmd_q    <= '0;
      mode_q       <= '0;
      op_active_q  <= 1'b0;
      retry_cnt_q  <= '0;
      retry_flag_q <= 1'b0;
      poll_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      lat_cmd_q    <= lat_cmd_d;
      mode_q       <= mode_d;
      op_active_q  <= op_active_d;
      retry_cnt_q  <= retry_cnt_d;
      retry_flag_q <= retry_flag_d;
      poll_cnt_q   <= poll_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign command     = cmd_q;
  assign seqr_idle   = (state_q == IDLE);
  assign seq_cmplt   = (state_q == DONE);
  assign rpt_error   = (state_q == ERR);
  assign check_stat  = (state_q == STAT_CHK);
  assign cnfrm_lk    = (state_q == LK_CHK);
  assign timeout_err = timeout_q;
  assign retry_cnt   = retry_cnt_q;
  assign OUT_STATE   = state_q;

endmodule
